orv64_icache_miss_ctrl: RTL

// Upstream neighbour of the I-cache sysbus refill stage. Queues I-cache line-miss requests, issues

---
 rtl/orv64_icache_miss_if.sv | 31 +++
 rtl/orv64_icache_miss_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/orv64_icache_miss_if.sv
// orv64_icache_miss_if
// Bundles the I-cache miss request port, the ic2isys/isys2ic sysbus refill
// port and the I-cache fill port of the I-cache miss controller.
// The master modport is the miss controller; the slave modport is its
// surroundings (I-cache and sysbus refill stage).
interface orv64_icache_miss_if #(
    parameter int PA_W   = 56,
    parameter int LINE_W = 256
);
    logic              miss_valid;
    logic              miss_ready;
    logic [PA_W-1:0]   miss_pc;
    logic              ic2isys_en;
    logic [PA_W-1:0]   ic2isys_pc;
    logic              isys2ic_valid;
    logic [LINE_W-1:0] isys2ic_rdata;
    logic              refill_valid;
    logic              refill_ready;
    logic [PA_W-1:0]   refill_addr;
    logic [LINE_W-1:0] refill_data;

    modport master (
        input  miss_valid, miss_pc, isys2ic_valid, isys2ic_rdata, refill_ready,
        output miss_ready, ic2isys_en, ic2isys_pc, refill_valid, refill_addr, refill_data
    );

    modport slave (
        output miss_valid, miss_pc, isys2ic_valid, isys2ic_rdata, refill_ready,
        input  miss_ready, ic2isys_en, ic2isys_pc, refill_valid, refill_addr, refill_data
    );
endinterface

// File: rtl/orv64_icache_miss_ctrl.sv
// orv64_icache_miss_ctrl
// Queues I-cache line misses, issues them one at a time to the sysbus refill
// stage (ic2isys_en/pc), captures the returned line and offers it to the
// I-cache fill port with a valid/ready handshake. A flush discards queued
// misses and marks an in-flight one for discard when its line returns.
// Optional feature macro: ORV64_ICACHE_MISS_MERGE_EN -- a miss to a line that
// is already queued, in flight (not marked for discard) or awaiting refill is
// accepted without being enqueued again.
module orv64_icache_miss_ctrl #(
    parameter int MISS_Q_DEPTH = 2,
    parameter int PA_W         = 56,
    parameter int LINE_W       = 256,
    parameter int OFFS_W       = $clog2(LINE_W / 8)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    output logic                busy,
    orv64_icache_miss_if.master bus
);

    localparam int QA_W = $clog2(MISS_Q_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [QA_W:0]     wr_ptr_q, wr_ptr_d;
    logic [QA_W:0]     rd_ptr_q, rd_ptr_d;
    logic [PA_W-1:0]   q_mem_q [MISS_Q_DEPTH];
    logic [PA_W-1:0]   q_mem_d [MISS_Q_DEPTH];
    logic              drop_q, drop_d;
    logic              en_q, en_d;
    logic [PA_W-1:0]   issue_pc_q, issue_pc_d;
    logic              refill_valid_q, refill_valid_d;
    logic [PA_W-1:0]   refill_addr_q, refill_addr_d;
    logic [LINE_W-1:0] refill_data_q, refill_data_d;

    logic              empty_s;
    logic              full_s;
    logic              merge_hit_s;
    logic              miss_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [PA_W-1:0]   miss_line_s;
    logic [PA_W-1:0]   head_s;
    logic              unused_offs_s;

    // Line address of the incoming miss; the offset bits carry no information.
    assign miss_line_s   = {bus.miss_pc[PA_W-1:OFFS_W], {OFFS_W{1'b0}}};
    assign unused_offs_s = ^bus.miss_pc[OFFS_W-1:0];

    // Wrap-bit pointers: equal means empty, equal index with differing wrap means full.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[QA_W] != rd_ptr_q[QA_W]) &&
                     (wr_ptr_q[QA_W-1:0] == rd_ptr_q[QA_W-1:0]);
    assign head_s  = q_mem_q[rd_ptr_q[QA_W-1:0]];

`ifdef ORV64_ICACHE_MISS_MERGE_EN
    logic [QA_W:0] occ_s;
    assign occ_s = wr_ptr_q - rd_ptr_q;

    // Detect a miss to a line already queued, in flight (not dropped) or awaiting refill.
    always_comb begin
        merge_hit_s = 1'b0;
        for (int i = 0; i < MISS_Q_DEPTH; i++) begin
            if (({1'b0, QA_W'(QA_W'(i) - rd_ptr_q[QA_W-1:0])} < occ_s) &&
                (q_mem_q[i] == miss_line_s)) begin
                merge_hit_s = 1'b1;
            end else begin
                merge_hit_s = merge_hit_s;
            end
        end
        if ((state_q == ST_ISSUE) && !drop_q && (issue_pc_q == miss_line_s)) begin
            merge_hit_s = 1'b1;
        end else if ((state_q == ST_RESP) && (refill_addr_q == miss_line_s)) begin
            merge_hit_s = 1'b1;
        end else begin
            merge_hit_s = merge_hit_s;
        end
    end
`else
    assign merge_hit_s = 1'b0;
`endif

    // A merged miss is acknowledged even when the queue is full; a flush swallows any push.
    assign miss_ready_s = !full_s || merge_hit_s;
    assign push_s       = bus.miss_valid && miss_ready_s && !merge_hit_s && !flush;
    assign pop_s        = (state_q == ST_IDLE) && !empty_s && !flush;

    // Miss queue next state: flush empties it by pulling the read pointer up to the write pointer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_mem_d  = q_mem_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push_s) begin
                q_mem_d[wr_ptr_q[QA_W-1:0]] = miss_line_s;
                wr_ptr_d = wr_ptr_q + (QA_W+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + (QA_W+1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Transaction FSM: issue one miss, wait for its line, hand it to the I-cache.
    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        en_d           = en_q;
        issue_pc_d     = issue_pc_q;
        refill_valid_d = refill_valid_q;
        refill_addr_d  = refill_addr_q;
        refill_data_d  = refill_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    issue_pc_d = head_s;
                    en_d       = 1'b1;
                    drop_d     = 1'b0;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The sysbus transaction cannot be aborted, so a flush only marks it for discard.
                if (bus.isys2ic_valid) begin
                    en_d = 1'b0;
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        refill_valid_d = 1'b1;
                        refill_addr_d  = issue_pc_q;
                        refill_data_d  = bus.isys2ic_rdata;
                        state_d        = ST_RESP;
                    end
                end else begin
                    en_d = 1'b1;
                    if (flush) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end
            ST_RESP: begin
                if (bus.refill_ready || flush) begin
                    refill_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    refill_valid_d = 1'b1;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                en_d           = 1'b0;
                drop_d         = 1'b0;
                refill_valid_d = 1'b0;
            end
        endcase
    end

    // State, queue and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            for (int i = 0; i < MISS_Q_DEPTH; i++) begin
                q_mem_q[i] <= '0;
            end
            drop_q         <= 1'b0;
            en_q           <= 1'b0;
            issue_pc_q     <= '0;
            refill_valid_q <= 1'b0;
            refill_addr_q  <= '0;
            refill_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            q_mem_q        <= q_mem_d;
            drop_q         <= drop_d;
            en_q           <= en_d;
            issue_pc_q     <= issue_pc_d;
            refill_valid_q <= refill_valid_d;
            refill_addr_q  <= refill_addr_d;
            refill_data_q  <= refill_data_d;
        end
    end

    assign bus.miss_ready   = miss_ready_s;
    assign bus.ic2isys_en   = en_q;
    assign bus.ic2isys_pc   = issue_pc_q;
    assign bus.refill_valid = refill_valid_q;
    assign bus.refill_addr  = refill_addr_q;
    assign bus.refill_data  = refill_data_q;
    assign busy             = !empty_s || (state_q != ST_IDLE);

endmodule
